// File: rtl/enc_acq_ctrl_pkg.sv
// Shared types and constants for the encoder acquisition controller.
// Holds the controller state encoding and the default sizing of the block.
// No logic; imported by the controller and its sample FIFO.
package enc_acq_ctrl_pkg;

   localparam int unsigned DEF_DEPTH = 4;    // sample FIFO depth, power of 2, >= 2
   localparam int unsigned DEF_TMO_W = 16;   // timeout counter width
   localparam int unsigned CNT_W     = 16;   // sample count width
   localparam int unsigned DATA_W    = 64;   // encoder counter / sample width

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_ERROR = 3'd4
   } state_e;

   // The encoder counter is armed only while waiting for and taking samples.
   function automatic logic is_armed_state(input state_e s);
      return (s == ST_ARM) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/enc_acq_fifo.sv
// Sample FIFO: 64-bit words, P_DEPTH entries, synchronous flush.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module enc_acq_fifo
   import enc_acq_ctrl_pkg::*;
#(
   parameter int unsigned P_DEPTH = DEF_DEPTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int unsigned AW      = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(P_DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [DATA_W-1:0] mem_q [P_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic              do_push, do_pop;

   assign full_o  = (cnt_q == DEPTH_C);
   assign empty_o = (cnt_q == '0);
   // Head reads as zero when empty so the output is clean after reset/flush.
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   // Pointer and occupancy update; flush overrides any push/pop.
   always_comb begin
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer/count registers, cleared asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage write; contents need no reset because occupancy gates the head.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/enc_acq_ctrl.sv
// Encoder acquisition controller: arms the counter, captures NSAMP samples into a FIFO.
// Latency: sample strobe to O_VALID is one cycle; O_DONE one cycle after the FIFO drains.
// Backpressure: consumer stalls via I_ACK; a strobe into a full, non-popping FIFO is an overrun error.
module enc_acq_ctrl
   import enc_acq_ctrl_pkg::*;
#(
   parameter int unsigned P_DEPTH = DEF_DEPTH,
   parameter int unsigned P_TMO_W = DEF_TMO_W
) (
   input  logic               CLK,
   input  logic               I_RST,
   input  logic               I_START,
   input  logic               I_ABORT,
   input  logic [CNT_W-1:0]   I_NSAMP,
   input  logic [P_TMO_W-1:0] I_TMO,
   output logic               O_ARM,
   input  logic [DATA_W-1:0]  I_CNT,
   input  logic               I_READY,
   input  logic               I_OVERFLOW,
   output logic [DATA_W-1:0]  O_DATA,
   output logic               O_VALID,
   input  logic               I_ACK,
   output logic               O_BUSY,
   output logic               O_DONE,
   output logic               O_ERR_TMO,
   output logic               O_ERR_OVR,
   output logic               O_OVF
);

   localparam logic [CNT_W-1:0]   SCNT_ONE = CNT_W'(1);
   localparam logic [P_TMO_W-1:0] TCNT_ONE = P_TMO_W'(1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   nsamp_q, nsamp_d;
   logic [P_TMO_W-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0]   scnt_q, scnt_d, scnt_inc;
   logic [P_TMO_W-1:0] tcnt_q, tcnt_d, tcnt_inc;
   logic               arm_q, arm_d;
   logic               done_q, done_d;
   logic               err_tmo_q, err_tmo_d;
   logic               err_ovr_q, err_ovr_d;
   logic               ovf_q, ovf_d;

   logic               fifo_push, fifo_pop, fifo_flush;
   logic               fifo_full, fifo_empty;
   logic               push_ok;

   assign O_ARM     = arm_q;
   assign O_BUSY    = (state_q != ST_IDLE);
   assign O_DONE    = done_q;
   assign O_ERR_TMO = err_tmo_q;
   assign O_ERR_OVR = err_ovr_q;
   assign O_OVF     = ovf_q;
   assign O_VALID   = !fifo_empty;

   assign fifo_pop  = O_VALID && I_ACK;
   // A full FIFO still takes a sample if the consumer frees a slot this cycle.
   assign push_ok   = !fifo_full || fifo_pop;
   assign scnt_inc  = scnt_q + SCNT_ONE;
   assign tcnt_inc  = tcnt_q + TCNT_ONE;

   enc_acq_fifo #(
      .P_DEPTH (P_DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (I_RST),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .wdata_i (I_CNT),
      .rdata_o (O_DATA),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Next-state, counters, sticky flags and FIFO control; abort has top priority.
   always_comb begin
      state_d    = state_q;
      nsamp_d    = nsamp_q;
      tmo_d      = tmo_q;
      scnt_d     = scnt_q;
      tcnt_d     = tcnt_q;
      done_d     = 1'b0;
      err_tmo_d  = err_tmo_q;
      err_ovr_d  = err_ovr_q;
      ovf_d      = ovf_q | (I_OVERFLOW & arm_q);
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;

      if ((state_q != ST_IDLE) && I_ABORT) begin
         state_d    = ST_IDLE;
         fifo_flush = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (I_START) begin
                  err_tmo_d = 1'b0;
                  err_ovr_d = 1'b0;
                  ovf_d     = 1'b0;
                  if (I_NSAMP == '0) begin
                     // Empty request completes immediately without arming.
                     done_d = 1'b1;
                  end else begin
                     state_d = ST_ARM;
                     nsamp_d = I_NSAMP;
                     tmo_d   = I_TMO;
                     scnt_d  = '0;
                     tcnt_d  = '0;
                  end
               end
            end
            ST_ARM: begin
               state_d = ST_RUN;
            end
            ST_RUN: begin
               if (I_READY) begin
                  if (push_ok) begin
                     fifo_push = 1'b1;
                     scnt_d    = scnt_inc;
                     tcnt_d    = '0;
                     if (scnt_inc == nsamp_q) state_d = ST_DRAIN;
                  end else begin
                     err_ovr_d = 1'b1;
                     state_d   = ST_ERROR;
                  end
               end else if (tmo_q != '0) begin
                  tcnt_d = tcnt_inc;
                  if (tcnt_inc == tmo_q) begin
                     err_tmo_d = 1'b1;
                     state_d   = ST_ERROR;
                  end
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_ERROR: begin
               fifo_flush = 1'b1;
               state_d    = ST_IDLE;
            end
            default: begin
               fifo_flush = 1'b1;
               state_d    = ST_IDLE;
            end
         endcase
      end

      arm_d = is_armed_state(state_d);
   end

   // State and status registers, all cleared asynchronously.
   always_ff @(posedge CLK or posedge I_RST) begin
      if (I_RST) begin
         state_q   <= ST_IDLE;
         nsamp_q   <= '0;
         tmo_q     <= '0;
         scnt_q    <= '0;
         tcnt_q    <= '0;
         arm_q     <= 1'b0;
         done_q    <= 1'b0;
         err_tmo_q <= 1'b0;
         err_ovr_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         nsamp_q   <= nsamp_d;
         tmo_q     <= tmo_d;
         scnt_q    <= scnt_d;
         tcnt_q    <= tcnt_d;
         arm_q     <= arm_d;
         done_q    <= done_d;
         err_tmo_q <= err_tmo_d;
         err_ovr_q <= err_ovr_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_enc_acq_ctrl.sv
// Bench for enc_acq_ctrl: directed scenarios plus random traffic against a queue-based model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Consumer acceptance is randomized to exercise FIFO backpressure and overrun.
module tb_enc_acq_ctrl;

   localparam int DEPTH = 4;
   localparam int TMO_W = 16;

   localparam int M_IDLE  = 0;
   localparam int M_ARM   = 1;
   localparam int M_RUN   = 2;
   localparam int M_DRAIN = 3;
   localparam int M_ERR   = 4;

   logic             CLK;
   logic             I_RST;
   logic             I_START;
   logic             I_ABORT;
   logic [15:0]      I_NSAMP;
   logic [TMO_W-1:0] I_TMO;
   logic             O_ARM;
   logic [63:0]      I_CNT;
   logic             I_READY;
   logic             I_OVERFLOW;
   logic [63:0]      O_DATA;
   logic             O_VALID;
   logic             I_ACK;
   logic             O_BUSY;
   logic             O_DONE;
   logic             O_ERR_TMO;
   logic             O_ERR_OVR;
   logic             O_OVF;

   int n_checks = 0;
   int n_errs   = 0;
   int done_seen;
   int arm_seen;
   bit ack_hi;

   // reference model state
   int          m_mode;
   logic [63:0] m_q[$];
   int          m_nsamp, m_tmo, m_scnt, m_tcnt;
   bit          m_arm, m_done, m_etmo, m_eovr, m_ovf;

   enc_acq_ctrl #(.P_DEPTH(DEPTH), .P_TMO_W(TMO_W)) dut (
      .CLK        (CLK),
      .I_RST      (I_RST),
      .I_START    (I_START),
      .I_ABORT    (I_ABORT),
      .I_NSAMP    (I_NSAMP),
      .I_TMO      (I_TMO),
      .O_ARM      (O_ARM),
      .I_CNT      (I_CNT),
      .I_READY    (I_READY),
      .I_OVERFLOW (I_OVERFLOW),
      .O_DATA     (O_DATA),
      .O_VALID    (O_VALID),
      .I_ACK      (I_ACK),
      .O_BUSY     (O_BUSY),
      .O_DONE     (O_DONE),
      .O_ERR_TMO  (O_ERR_TMO),
      .O_ERR_OVR  (O_ERR_OVR),
      .O_OVF      (O_OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_q.delete();
      m_nsamp = 0; m_tmo = 0; m_scnt = 0; m_tcnt = 0;
      m_arm = 0; m_done = 0; m_etmo = 0; m_eovr = 0; m_ovf = 0;
   endtask

   // Advance the model by one rising edge using the inputs currently applied.
   task automatic model_step();
      bit pop, push, flush, ndone;
      int nmode;
      pop   = (m_q.size() > 0) && I_ACK;
      push  = 0;
      flush = 0;
      ndone = 0;
      nmode = m_mode;
      if (I_OVERFLOW && m_arm) m_ovf = 1;
      if (m_mode != M_IDLE && I_ABORT) begin
         nmode = M_IDLE;
         flush = 1;
      end else begin
         case (m_mode)
            M_IDLE: if (I_START) begin
               m_etmo = 0; m_eovr = 0; m_ovf = 0;
               if (I_NSAMP == 0) ndone = 1;
               else begin
                  nmode = M_ARM;
                  m_nsamp = int'(I_NSAMP);
                  m_tmo = int'(I_TMO);
                  m_scnt = 0;
                  m_tcnt = 0;
               end
            end
            M_ARM: nmode = M_RUN;
            M_RUN: begin
               if (I_READY) begin
                  if (m_q.size() < DEPTH || pop) begin
                     push = 1;
                     m_scnt++;
                     m_tcnt = 0;
                     if (m_scnt == m_nsamp) nmode = M_DRAIN;
                  end else begin
                     m_eovr = 1;
                     nmode = M_ERR;
                  end
               end else if (m_tmo != 0) begin
                  m_tcnt++;
                  if (m_tcnt == m_tmo) begin
                     m_etmo = 1;
                     nmode = M_ERR;
                  end
               end
            end
            M_DRAIN: if (m_q.size() == 0) begin
               ndone = 1;
               nmode = M_IDLE;
            end
            default: begin
               flush = 1;
               nmode = M_IDLE;
            end
         endcase
      end
      if (pop) m_q.delete(0);
      if (push) m_q.push_back(I_CNT);
      if (flush) m_q.delete();
      m_mode = nmode;
      m_done = ndone;
      m_arm  = (nmode == M_ARM) || (nmode == M_RUN);
   endtask

   task automatic compare_all();
      chk("arm", O_ARM, m_arm);
      chk("busy", O_BUSY, m_mode != M_IDLE);
      chk("done", O_DONE, m_done);
      chk("err_tmo", O_ERR_TMO, m_etmo);
      chk("err_ovr", O_ERR_OVR, m_eovr);
      chk("ovf", O_OVF, m_ovf);
      chk("valid", O_VALID, m_q.size() > 0);
      if (m_q.size() > 0) chk("data", O_DATA, m_q[0]);
      if (O_DONE === 1'b1) done_seen++;
      if (O_ARM === 1'b1) arm_seen++;
   endtask

   // One clock: check outputs, apply new inputs, advance the model.
   task automatic step(input bit st, input bit ab, input int ns, input int tm,
                       input bit rdy, input bit ak, input bit ov);
      @(negedge CLK);
      compare_all();
      I_START    = st;
      I_ABORT    = ab;
      I_NSAMP    = 16'(ns);
      I_TMO      = TMO_W'(tm);
      I_READY    = rdy;
      I_ACK      = ak;
      I_OVERFLOW = ov;
      I_CNT      = {$urandom, $urandom};
      model_step();
   endtask

   task automatic do_reset();
      @(negedge CLK);
      I_START = 0; I_ABORT = 0; I_READY = 0; I_ACK = 0; I_OVERFLOW = 0;
      I_NSAMP = '0; I_TMO = '0;
      I_RST = 1'b1;
      #1;
      chk("rst_arm", O_ARM, 0);
      chk("rst_valid", O_VALID, 0);
      chk("rst_data", O_DATA, 0);
      chk("rst_busy", O_BUSY, 0);
      chk("rst_done", O_DONE, 0);
      chk("rst_err_tmo", O_ERR_TMO, 0);
      chk("rst_err_ovr", O_ERR_OVR, 0);
      chk("rst_ovf", O_OVF, 0);
      model_reset();
      @(negedge CLK);
      I_RST = 1'b0;
      model_step();
   endtask

   initial begin
      I_RST = 1'b1;
      I_START = 0; I_ABORT = 0; I_READY = 0; I_ACK = 0; I_OVERFLOW = 0;
      I_NSAMP = '0; I_TMO = '0; I_CNT = '0;
      ack_hi = 1'b1;
      model_reset();
      do_reset();

      // three samples, no timeout, consumer always ready
      done_seen = 0;
      for (int c = 0; c < 20; c++)
         step(c == 0, 0, 3, 0, (c == 5 || c == 9 || c == 13), 1, 0);
      chk("s31_done_cnt", done_seen, 1);
      chk("s31_busy", O_BUSY, 0);
      chk("s31_arm", O_ARM, 0);

      // overrun: consumer stalled, fifth strobe overflows a 4-deep FIFO
      done_seen = 0;
      for (int c = 0; c < 16; c++)
         step(c == 0, 0, 8, 0, (c == 2 || c == 4 || c == 6 || c == 8 || c == 10), 0, 0);
      chk("s32_err_ovr", O_ERR_OVR, 1);
      chk("s32_valid", O_VALID, 0);
      chk("s32_arm", O_ARM, 0);
      chk("s32_done_cnt", done_seen, 0);

      // timeout after 10 idle RUN cycles: ARM cycle + 10 RUN cycles armed
      arm_seen = 0;
      for (int c = 0; c < 16; c++)
         step(c == 0, 0, 2, 10, 0, 1, 0);
      chk("s33_arm_cycles", arm_seen, 11);
      chk("s33_err_tmo", O_ERR_TMO, 1);
      chk("s33_busy", O_BUSY, 0);

      // counter overflow while armed is flagged but does not stop the run
      done_seen = 0;
      for (int c = 0; c < 12; c++)
         step(c == 0, 0, 2, 0, (c == 3 || c == 5), 1, (c == 4));
      chk("s34_ovf", O_OVF, 1);
      chk("s34_done_cnt", done_seen, 1);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("s34_ovf_clr", O_OVF, 0);
      chk("s34_done_zero", O_DONE, 1);

      // abort with two words queued, then a zero-length start
      for (int c = 0; c < 7; c++)
         step(c == 0, c == 6, 5, 0, (c == 2 || c == 3), 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("s35_valid", O_VALID, 0);
      chk("s35_arm", O_ARM, 0);
      chk("s35_busy", O_BUSY, 0);
      arm_seen = 0;
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("s35_done", O_DONE, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("s35_arm_cycles", arm_seen, 0);

      // reset in the middle of a run, then a single-sample run
      for (int c = 0; c < 5; c++)
         step(c == 0, 0, 4, 0, (c == 2 || c == 3), 0, 0);
      do_reset();
      done_seen = 0;
      for (int c = 0; c < 10; c++)
         step(c == 0, 0, 1, 0, (c == 3), 1, 0);
      chk("s36_done_cnt", done_seen, 1);
      chk("s36_busy", O_BUSY, 0);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         if (c % 400 == 399) begin
            do_reset();
         end else begin
            step($urandom_range(0, 7) == 0,
                 $urandom_range(0, 79) == 0,
                 int'($urandom_range(0, 6)),
                 ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 12)),
                 $urandom_range(0, 2) == 0,
                 ack_hi ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 3),
                 $urandom_range(0, 24) == 0);
         end
         if (c % 250 == 0) ack_hi = !ack_hi;
      end
      step(0, 0, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
